// File: rtl/memory_access_unit_pkg.sv
// memory_access_unit_pkg: opcodes and FSM states shared by the load/store unit and the CPU decoder.
package memory_access_unit_pkg;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
endpackage

// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store unit driving data_memory (async read, sync write),
// with LOAD, STORE, SWAP and atomic INCREMENT behind valid/ready handshakes.
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;

    assign w_accept = i_req_valid && o_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid) w_next = (i_req_op == OP_STORE) ? S_WRITE : S_READ;
            S_READ:  w_next = (r_op == OP_LOAD) ? S_RESP : S_WRITE;
            S_WRITE: w_next = S_RESP;
            S_RESP:  if (i_resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op    <= OP_LOAD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= i_req_op;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
            if (r_state == S_READ) r_rdata <= i_mem_rdata;
        end
    end

    // All memory-side outputs come from registered state only; nothing leaks from req_*.
    assign o_req_ready   = (r_state == S_IDLE);
    assign o_resp_valid  = (r_state == S_RESP);
    assign o_resp_rdata  = (r_op == OP_STORE) ? r_wdata : r_rdata;
    assign o_mem_read    = (r_state == S_READ);
    assign o_mem_write   = (r_state == S_WRITE);
    assign o_mem_address = r_addr;
    assign o_mem_wdata   = (r_op == OP_INC) ? r_rdata + DATA_WIDTH'(1) : r_wdata;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: drives the unit against a behavioural data memory and checks
// every response, latency and memory side effect against an array reference model.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    logic       clk, rst_n;
    logic       req_valid, req_ready, resp_valid, resp_ready;
    logic [1:0] req_op;
    logic [4:0] req_addr, mem_address;
    logic [7:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
    logic       mem_read, mem_write;
    logic       mem_clr;
    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    int         n_cmp = 0;
    int         n_err = 0;

    memory_access_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_address(mem_address), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Responder: word i initialised to i, except word 17 which starts at FF.
    assign mem_rdata = mem[mem_address];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 17) ? 8'hFF : 8'(i);
        end else if (mem_write) begin
            mem[mem_address] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n && !mem_clr) check("rw_excl", 32'(mem_read & mem_write), 0);

    // Issue one request at a negedge with the unit idle; returns at a negedge with it idle again.
    task automatic do_op(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                         input int hold, input bit pend);
        logic [7:0] old, exp, wexp, r0;
        int k;
        old  = ref_mem[a];
        exp  = (op == OP_STORE) ? d : old;
        wexp = (op == OP_INC) ? old + 8'd1 : d;
        if (op != OP_LOAD) ref_mem[a] = wexp;
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1;
        check("idle_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 0;
        req_wdata = ~d;
        k = 0;
        while (!resp_valid && k < 6) begin
            check("busy_ready", 32'(req_ready), 0);
            check("mem_addr", 32'(mem_address), 32'(a));
            if (k == 0 && op != OP_STORE) check("mem_read", 32'(mem_read), 1);
            if ((k == 0 && op == OP_STORE) || (k == 1 && op[1])) begin
                check("mem_write", 32'(mem_write), 1);
                check("mem_wdata", 32'(mem_wdata), 32'(wexp));
            end
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), (op == OP_LOAD || op == OP_STORE) ? 1 : 2);
        if (!resp_valid) return;
        check("resp_rdata", 32'(resp_rdata), 32'(exp));
        check("resp_mem_idle", 32'({mem_read, mem_write}), 0);
        r0 = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                req_valid = 1; req_op = OP_LOAD; req_addr = 5'(a + 1);
            end
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 1);
            check("hold_rdata", 32'(resp_rdata), 32'(r0));
            check("hold_ready", 32'(req_ready), 0);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check("post_valid", 32'(resp_valid), 0);
        check("post_ready", 32'(req_ready), 1);
    endtask

    initial begin
        rst_n = 0; mem_clr = 1;
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = (i == 17) ? 8'hFF : 8'(i);
        repeat (2) @(negedge clk);
        mem_clr = 0;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_rdata", 32'(resp_rdata), 0);
        check("rst_mem_ctl", 32'({mem_read, mem_write}), 0);
        check("rst_mem_addr", 32'(mem_address), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        rst_n = 1;
        @(negedge clk);
        do_op(OP_LOAD, 5, 8'h00, 0, 0);
        do_op(OP_STORE, 3, 8'hA5, 0, 0);
        do_op(OP_LOAD, 3, 8'h00, 0, 0);
        do_op(OP_SWAP, 17, 8'h3C, 0, 0);
        do_op(OP_LOAD, 17, 8'h00, 0, 0);
        do_op(OP_STORE, 17, 8'hFF, 0, 0);
        do_op(OP_INC, 17, 8'h55, 0, 0);
        do_op(OP_LOAD, 17, 8'h00, 0, 0);
        do_op(OP_INC, 4, 8'h00, 0, 0);
        do_op(OP_LOAD, 4, 8'h00, 0, 0);
        do_op(OP_LOAD, 5, 8'h00, 5, 1);
        do_op(OP_LOAD, 6, 8'h00, 0, 0);
        // Abort a STORE while its write strobe is up, before the writing edge.
        req_op = OP_STORE; req_addr = 9; req_wdata = 8'h77; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        check("abort_write_up", 32'(mem_write), 1);
        #2 rst_n = 0;
        #1;
        check("abort_mem_write", 32'(mem_write), 0);
        check("abort_resp_valid", 32'(resp_valid), 0);
        check("abort_req_ready", 32'(req_ready), 1);
        check("abort_mem_addr", 32'(mem_address), 0);
        @(negedge clk);
        rst_n = 1;
        check("abort_mem9", 32'(mem[9]), 32'h09);
        @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 0);
        for (int n = 0; n < 300; n++)
            do_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) check($sformatf("final_mem%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
